// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_pkg: opcodes, sequencer states and datapath select encodings           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  localparam logic [3:0] c_op_rtype = 4'h0;
  localparam logic [3:0] c_op_addi  = 4'h1;
  localparam logic [3:0] c_op_lw    = 4'h8;
  localparam logic [3:0] c_op_sw    = 4'h9;
  localparam logic [3:0] c_op_beq   = 4'hA;
  localparam logic [3:0] c_op_bne   = 4'hB;
  localparam logic [3:0] c_op_jmp   = 4'hC;
  localparam logic [3:0] c_op_halt  = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] c_aluop_add    = 2'b00;
  localparam logic [1:0] c_aluop_sub    = 2'b01;
  localparam logic [1:0] c_aluop_funct  = 2'b10;

  localparam logic [1:0] c_pcsrc_alu    = 2'd0;
  localparam logic [1:0] c_pcsrc_aluout = 2'd1;
  localparam logic [1:0] c_pcsrc_jump   = 2'd2;

  localparam logic [1:0] c_srcb_rt      = 2'd0;
  localparam logic [1:0] c_srcb_one     = 2'd1;
  localparam logic [1:0] c_srcb_imm     = 2'd2;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       halted;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      c_op_rtype, c_op_addi, c_op_lw, c_op_sw,
      c_op_beq, c_op_bne, c_op_jmp, c_op_halt: is_legal_op = 1'b1;
      default:                                 is_legal_op = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_output_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mc_output_decode: combinational control outputs from state/opcode/flags    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mc_output_decode
  import cpu_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       run,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        if (run) begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = c_srcb_one;
          ctrl.alu_op    = c_aluop_add;
          // IR and PC+1 are captured on the edge that completes the fetch
          if (mem_ready) begin
            ctrl.ir_write = 1'b1;
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = c_pcsrc_alu;
          end
        end
      end
      S_DECODE: begin
        ctrl.alu_src_b = c_srcb_imm;
        ctrl.alu_op    = c_aluop_add;
        if (opcode == c_op_jmp) begin
          ctrl.pc_write = 1'b1;
          ctrl.pc_src   = c_pcsrc_jump;
        end
      end
      S_EXEC: begin
        case (opcode)
          c_op_rtype: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = c_srcb_rt;
            ctrl.alu_op    = c_aluop_funct;
          end
          c_op_addi, c_op_lw, c_op_sw: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = c_srcb_imm;
            ctrl.alu_op    = c_aluop_add;
          end
          c_op_beq, c_op_bne: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = c_srcb_rt;
            ctrl.alu_op    = c_aluop_sub;
            ctrl.pc_src    = c_pcsrc_aluout;
            ctrl.pc_write  = (opcode == c_op_beq) ? zero : ~zero;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_read  = (opcode == c_op_lw);
        ctrl.mem_write = (opcode == c_op_sw);
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = (opcode == c_op_rtype);
        ctrl.mem_to_reg = (opcode == c_op_lw);
      end
      S_HALT:  ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the 24-bit CPU  |
// | Option: MC_ILLEGAL_TRAP_EN traps illegal opcodes to HALT, adds Illegal.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multicycle_control
  import cpu_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Run,
  input  logic [3:0] Opcode,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       Halted,
  output logic [2:0] State
`ifdef MC_ILLEGAL_TRAP_EN
  ,
  output logic       Illegal
`endif
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;
  ctrl_t  w_ctrl_out;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: if (Run && MemReady) w_next = S_DECODE;
      S_DECODE: begin
        if (Opcode == c_op_jmp)       w_next = S_FETCH;
        else if (Opcode == c_op_halt) w_next = S_HALT;
        else if (!is_legal_op(Opcode))
`ifdef MC_ILLEGAL_TRAP_EN
          w_next = S_HALT;
`else
          w_next = S_FETCH;
`endif
        else                          w_next = S_EXEC;
      end
      S_EXEC: begin
        case (Opcode)
          c_op_rtype, c_op_addi: w_next = S_WB;
          c_op_lw, c_op_sw:      w_next = S_MEM;
          default:               w_next = S_FETCH;
        endcase
      end
      S_MEM:   if (MemReady) w_next = (Opcode == c_op_lw) ? S_WB : S_FETCH;
      S_WB:    w_next = S_FETCH;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  mc_output_decode u_decode (
    .state     (r_state),
    .opcode    (Opcode),
    .zero      (Zero),
    .run       (Run),
    .mem_ready (MemReady),
    .ctrl      (w_ctrl)
  );

  // Reset masks outputs combinationally so an in-flight memory request drops at once
  assign w_ctrl_out = Reset ? '0 : w_ctrl;

  assign IorD     = w_ctrl_out.iord;
  assign MemRead  = w_ctrl_out.mem_read;
  assign MemWrite = w_ctrl_out.mem_write;
  assign IRWrite  = w_ctrl_out.ir_write;
  assign PCWrite  = w_ctrl_out.pc_write;
  assign PCSrc    = w_ctrl_out.pc_src;
  assign ALUSrcA  = w_ctrl_out.alu_src_a;
  assign ALUSrcB  = w_ctrl_out.alu_src_b;
  assign ALUOp    = w_ctrl_out.alu_op;
  assign RegDst   = w_ctrl_out.reg_dst;
  assign RegWrite = w_ctrl_out.reg_write;
  assign MemToReg = w_ctrl_out.mem_to_reg;
  assign Halted   = w_ctrl_out.halted;
  assign State    = r_state;

`ifdef MC_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      r_illegal <= 1'b0;
    else if (r_state == S_DECODE && !is_legal_op(Opcode))
      r_illegal <= 1'b1;
  end

  assign Illegal = r_illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_control: directed checks of the multi-cycle sequencer        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multicycle_control;

  logic       Clock = 1'b0;
  logic       Reset, Run, Zero, MemReady;
  logic [3:0] Opcode;
  logic       IorD, MemRead, MemWrite, IRWrite, PCWrite;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;
  logic       ALUSrcA, RegDst, RegWrite, MemToReg, Halted;
  logic [2:0] State;
`ifdef MC_ILLEGAL_TRAP_EN
  logic       Illegal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  multicycle_control dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Run      (Run),
    .Opcode   (Opcode),
    .Zero     (Zero),
    .MemReady (MemReady),
    .IorD     (IorD),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .IRWrite  (IRWrite),
    .PCWrite  (PCWrite),
    .PCSrc    (PCSrc),
    .ALUSrcA  (ALUSrcA),
    .ALUSrcB  (ALUSrcB),
    .ALUOp    (ALUOp),
    .RegDst   (RegDst),
    .RegWrite (RegWrite),
    .MemToReg (MemToReg),
    .Halted   (Halted),
    .State    (State)
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    .Illegal  (Illegal)
`endif
  );

  // {IorD,MemRead,MemWrite,IRWrite,PCWrite}_PCSrc_ALUSrcA_ALUSrcB_ALUOp_{RegDst,RegWrite,MemToReg,Halted}
  logic [15:0] ctrl;
  assign ctrl = {IorD, MemRead, MemWrite, IRWrite, PCWrite, PCSrc, ALUSrcA,
                 ALUSrcB, ALUOp, RegDst, RegWrite, MemToReg, Halted};

  localparam logic [15:0] C_IDLE      = 16'b00000_00_0_00_00_0000;
  localparam logic [15:0] C_FETCH_RDY = 16'b01011_00_0_01_00_0000;
  localparam logic [15:0] C_FETCH_WT  = 16'b01000_00_0_01_00_0000;
  localparam logic [15:0] C_DECODE    = 16'b00000_00_0_10_00_0000;
  localparam logic [15:0] C_DEC_JMP   = 16'b00001_10_0_10_00_0000;
  localparam logic [15:0] C_EX_R      = 16'b00000_00_1_00_10_0000;
  localparam logic [15:0] C_EX_I      = 16'b00000_00_1_10_00_0000;
  localparam logic [15:0] C_EX_BR_T   = 16'b00001_01_1_00_01_0000;
  localparam logic [15:0] C_EX_BR_N   = 16'b00000_01_1_00_01_0000;
  localparam logic [15:0] C_MEM_LW    = 16'b11000_00_0_00_00_0000;
  localparam logic [15:0] C_MEM_SW    = 16'b10100_00_0_00_00_0000;
  localparam logic [15:0] C_WB_R      = 16'b00000_00_0_00_00_1100;
  localparam logic [15:0] C_WB_LW     = 16'b00000_00_0_00_00_0110;
  localparam logic [15:0] C_HALT      = 16'b00000_00_0_00_00_0001;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at posedge+2 with inputs already set; checks at +3, returns at next posedge+2
  task automatic step(input string tag, input logic [2:0] st, input logic [15:0] c);
    #1;
    chk({tag, "_state"}, 16'(State), 16'(st));
    chk({tag, "_ctrl"}, ctrl, c);
    @(posedge Clock);
    #2;
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b1; MemReady = 1'b1; Zero = 1'b0; Opcode = 4'h0;
    @(posedge Clock);
    #2;
    step("reset_a", 3'd0, C_IDLE);
    step("reset_b", 3'd0, C_IDLE);
`ifdef MC_ILLEGAL_TRAP_EN
    chk("illegal_after_reset", 16'(Illegal), 16'd0);
`endif
    Reset = 1'b0;

    // RTYPE, zero-wait: 0,1,2,4,0
    step("rt_fetch", 3'd0, C_FETCH_RDY);
    step("rt_dec",   3'd1, C_DECODE);
    step("rt_exec",  3'd2, C_EX_R);
    step("rt_wb",    3'd4, C_WB_R);

    // LW with two wait cycles in MEM: 7 cycles total
    Opcode = 4'h8;
    step("lw_fetch", 3'd0, C_FETCH_RDY);
    step("lw_dec",   3'd1, C_DECODE);
    step("lw_exec",  3'd2, C_EX_I);
    MemReady = 1'b0;
    step("lw_mem1",  3'd3, C_MEM_LW);
    step("lw_mem2",  3'd3, C_MEM_LW);
    MemReady = 1'b1;
    step("lw_mem3",  3'd3, C_MEM_LW);
    step("lw_wb",    3'd4, C_WB_LW);

    // BEQ taken, preceded by one fetch wait cycle
    Opcode = 4'hA;
    MemReady = 1'b0;
    step("beq_fwait", 3'd0, C_FETCH_WT);
    MemReady = 1'b1;
    step("beq_fetch", 3'd0, C_FETCH_RDY);
    step("beq_dec",   3'd1, C_DECODE);
    Zero = 1'b1;
    step("beq_exec",  3'd2, C_EX_BR_T);

    // BNE not taken with Zero=1
    Opcode = 4'hB;
    step("bne_fetch", 3'd0, C_FETCH_RDY);
    step("bne_dec",   3'd1, C_DECODE);
    step("bne_exec",  3'd2, C_EX_BR_N);
    Zero = 1'b0;

    // JMP completes in DECODE
    Opcode = 4'hC;
    step("jmp_fetch", 3'd0, C_FETCH_RDY);
    step("jmp_dec",   3'd1, C_DEC_JMP);

    // Run low holds FETCH with all outputs idle
    Run = 1'b0;
    step("norun_a", 3'd0, C_IDLE);
    step("norun_b", 3'd0, C_IDLE);
    Run = 1'b1;

    // SW: asynchronous reset in the middle of a stalled MEM access
    Opcode = 4'h9;
    step("sw_fetch", 3'd0, C_FETCH_RDY);
    step("sw_dec",   3'd1, C_DECODE);
    step("sw_exec",  3'd2, C_EX_I);
    MemReady = 1'b0;
    #1;
    chk("sw_mem_state", 16'(State), 16'd3);
    chk("sw_mem_ctrl", ctrl, C_MEM_SW);
    #1;
    Reset = 1'b1;
    #1;
    chk("sw_rst_state", 16'(State), 16'd0);
    chk("sw_rst_ctrl", ctrl, C_IDLE);
    @(posedge Clock);
    #2;
    Reset = 1'b0;
    MemReady = 1'b1;

    // HALT is sticky until reset
    Opcode = 4'hF;
    step("halt_fetch", 3'd0, C_FETCH_RDY);
    step("halt_dec",   3'd1, C_DECODE);
    step("halt_a",     3'd5, C_HALT);
    step("halt_b",     3'd5, C_HALT);
    Reset = 1'b1;
    step("halt_rst",   3'd0, C_IDLE);
    Reset = 1'b0;

    // Illegal opcode 5
    Opcode = 4'h5;
    step("ill_fetch", 3'd0, C_FETCH_RDY);
    step("ill_dec",   3'd1, C_DECODE);
`ifdef MC_ILLEGAL_TRAP_EN
    #1;
    chk("ill_flag", 16'(Illegal), 16'd1);
    #1;
    step("ill_halt_a", 3'd5, C_HALT);
    step("ill_halt_b", 3'd5, C_HALT);
    chk("ill_flag_sticky", 16'(Illegal), 16'd1);
`else
    MemReady = 1'b0;
    step("ill_nop", 3'd0, C_FETCH_WT);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the 24-bit CPU datapath. It replaces the single-cycle control decode with a state machine that splits each instruction into FETCH, DECODE, EXEC, MEM and WB steps. It drives the datapath's mux selects and write enables each cycle, and it stalls on a ready/valid style handshake with the shared instruction/data memory. It sits beside the datapath at CPU top level. It takes `Opcode` from the instruction register and `Zero` from the ALU.

## Interface
Parameters: none. Encodings are package constants.
- `Clock` in 1: sole clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `Run` in 1: fetch enable, sampled in FETCH only.
- `Opcode` in 4: IR[23:20], stable from DECODE onward.
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory completed current access this cycle.
- `IorD` out 1: memory address select, 0=PC, 1=ALUOut.
- `MemRead`, `MemWrite` out 1: memory request, held until `MemReady`.
- `IRWrite`, `PCWrite` out 1: register load enables.
- `PCSrc` out 2: next-PC select, 0=ALU (PC+1), 1=ALUOut (branch target), 2=jump field.
- `ALUSrcA` out 1: ALU operand A select, 0=PC, 1=rs.
- `ALUSrcB` out 2: ALU operand B select, 0=rt, 1=const 1, 2=sign-extended imm.
- `ALUOp` out 2: 00=add, 01=sub, 10=funct.
- `RegDst`, `RegWrite`, `MemToReg` out 1: register file write controls.
- `Halted` out 1: core stopped.
- `State` out 3: current state, for debug.

## Operation
- Opcodes: RTYPE=0, ADDI=1, LW=8, SW=9, BEQ=A, BNE=B, JMP=C, HALT=F. All other opcodes are illegal.
- Outputs are decoded from the registered state, `Opcode` and `Zero`. Unlisted outputs are 0.
- Memory handshake:
  - A request stays asserted with constant address select until a cycle with `MemReady`=1.
  - The state advances on that edge.
  - `MemReady` outside a request is ignored.
- FETCH (0):
  - If `Run`=0: all outputs 0; stay in FETCH.
  - Else: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=00.
  - On `MemReady`: IRWrite=1, PCWrite=1, PCSrc=0; next state DECODE.
- DECODE (1):
  - Compute branch target: ALUSrcA=0, ALUSrcB=2, ALUOp=00.
  - JMP: PCWrite=1, PCSrc=2; next FETCH.
  - HALT: next HALT.
  - Illegal: see Configuration.
  - Other opcodes: next EXEC.
- EXEC (2):
  - RTYPE: ALUSrcA=1, ALUSrcB=0, ALUOp=10; next WB.
  - ADDI, LW, SW: ALUSrcA=1, ALUSrcB=2, ALUOp=00. ADDI goes to WB; LW and SW go to MEM.
  - BEQ/BNE: ALUSrcA=1, ALUSrcB=0, ALUOp=01, PCSrc=1.
    - PCWrite = `Zero` for BEQ, `!Zero` for BNE.
    - Next FETCH.
- MEM (3): IorD=1, with MemRead (LW) or MemWrite (SW). On `MemReady`, LW goes to WB and SW goes to FETCH.
- WB (4): RegWrite=1, then next FETCH.
  - RTYPE: RegDst=1, MemToReg=0.
  - ADDI: RegDst=0, MemToReg=0.
  - LW: RegDst=0, MemToReg=1.
- HALT (5): Halted=1, all other outputs 0. Left only by `Reset`.
- Encodings 6–7 are unreachable and recover to FETCH on the next edge.

## Timing
- Reset:
  - Asserting `Reset` forces State=FETCH immediately, with no clock edge needed.
  - While `Reset` is high, every output is 0, including MemRead in FETCH.
  - This holds when reset arrives mid-access. The memory side must drop the request.
- Cycles per instruction with zero-wait memory (`MemReady` high in the first request cycle):

  | Instruction | Cycles |
  |---|---|
  | RTYPE, ADDI, SW | 4 |
  | LW | 5 |
  | BEQ/BNE | 3 |
  | JMP | 2 |
  | HALT | 2, to reach HALT |

- Each extra cycle with `MemReady`=0 in FETCH or MEM adds exactly 1 cycle.
- `Zero` is combinational into PCWrite in EXEC only. It must settle before the rising edge.
- `Run` falling mid-instruction has no effect until the next FETCH.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in DECODE goes to HALT.
  - Adds output `Illegal` (1 bit), which is set on that transition, sticky, and cleared only by Reset.
- Not defined:
  - An illegal opcode is a NOP: DECODE goes to FETCH with no writes.
  - The `Illegal` port does not exist.

## Structure
- `cpu_pkg` holds:
  - opcode constants;
  - the state enum (3 bits, values as listed in Operation);
  - ALUOp, PCSrc and ALUSrcB encodings.
- The datapath uses the same constants.
- One natural sub-module: `mc_output_decode`, a purely combinational mapping from (state, Opcode, Zero, Run) to the control outputs.
- `multicycle_control` keeps the state register, next-state logic and the illegal flag.

## Test plan
- Reset held, `Run`=1, then release with `MemReady`=1 → all outputs 0 during reset; first cycle after release State=0, MemRead=1, IorD=0.
- RTYPE with zero-wait memory → State sequence 0,1,2,4,0. RegWrite=1 and RegDst=1 only in state 4. ALUOp=10 in state 2.
- LW with `MemReady` low for 2 cycles in MEM → MEM lasts 3 cycles with MemRead=1 and IorD=1 held; WB has MemToReg=1; total 7 cycles.
- BEQ with Zero=1 then BNE with Zero=1 → BEQ gives PCWrite=1, PCSrc=1 in EXEC; BNE gives PCWrite=0; each takes 3 cycles.
- `Reset` asserted asynchronously mid-MEM of SW → MemWrite drops to 0 before the next edge; State=0.
- Opcode=4'h5 → with `MC_ILLEGAL_TRAP_EN`, Halted=1 and Illegal=1 from the cycle after DECODE; without it, State returns to 0 and no write enable is asserted.
